// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned multiply/divide unit for the execute stage.
// Shift-add multiply (LSB-first) and restoring divide (MSB-first) share one
// 2*DW-bit accumulator. Each operation takes DW cycles in RUN, then one DONE
// cycle in which Result is valid. Stall holds the EX/MEM register group.

module ex_muldiv_iter #(
    parameter int unsigned DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Start,
    input  logic [1:0]    Op,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic          Flush,
    output logic          Busy,
    output logic          Stall,
    output logic          Done,
    output logic [DW-1:0] Result
);

    localparam int unsigned CntW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [DW-1:0]   opnd_q, opnd_d;
    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   result_q, result_d;

    logic            idle_or_done;
    logic            launch;
    logic            last_iter;

    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next;
    logic [DW:0]     div_shift;
    logic            div_ge;
    logic [DW-1:0]   div_rem;
    logic [2*DW-1:0] div_next;
    logic [2*DW-1:0] acc_step;

    assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
    assign launch       = idle_or_done && Start && !Flush;
    assign last_iter    = (state_q == StRun) && (cnt_q == CntW'(1));

    // State register with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (launch) state_d = StRun;
            end
            StRun: begin
                if (Flush)          state_d = StIdle;
                else if (last_iter) state_d = StDone;
            end
            StDone: begin
                if (launch) state_d = StRun;
                else        state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore status outputs plus the combinational stall request.
    always_comb begin
        Busy   = (state_q == StRun);
        Done   = (state_q == StDone);
        Stall  = Busy || (Start && idle_or_done && !Flush);
        Result = result_q;
    end

    // One iteration of either algorithm from the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[DW-1:1]};

        // Guard bit in div_shift keeps the trial compare exact.
        div_shift = acc_q[2*DW-1:DW-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // The true difference is below the divisor, so DW bits suffice.
        div_rem   = div_ge ? (div_shift[DW-1:0] - opnd_q) : div_shift[DW-1:0];
        div_next  = {div_rem, acc_q[DW-2:0], div_ge};

        acc_step  = op_q[1] ? div_next : mul_next;
    end

    // Datapath next-state: latch on launch, iterate in RUN, capture result on last step.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (launch) begin
            cnt_d  = CntW'(DW);
            op_d   = Op;
            opnd_d = Op[1] ? B : A;
            acc_d  = {{DW{1'b0}}, (Op[1] ? A : B)};
        end else if ((state_q == StRun) && !Flush) begin
            cnt_d = cnt_q - CntW'(1);
            acc_d = acc_step;
            if (last_iter) begin
                // Op[0] selects the high half: MULHU product high, REMU remainder.
                result_d = op_q[0] ? acc_step[2*DW-1:DW] : acc_step[DW-1:0];
            end
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Self-checking bench for ex_muldiv_iter: directed scenarios plus random
// operations checked against a plain-arithmetic reference model.

module tb_ex_muldiv_iter;

    localparam int unsigned DW = 32;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [1:0]    Op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          Flush;
    logic          Busy;
    logic          Stall;
    logic          Done;
    logic [DW-1:0] Result;

    int total = 0;
    int bad   = 0;

    ex_muldiv_iter #(.DW(DW)) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .Flush  (Flush),
        .Busy   (Busy),
        .Stall  (Stall),
        .Done   (Done),
        .Result (Result)
    );

    always #5 Clk = ~Clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_model(input logic [1:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        longint unsigned prod;
        prod = longint'(a) * longint'(b);
        case (op)
            OpMul:   return prod[DW-1:0];
            OpMulhu: return prod[2*DW-1:DW];
            OpDivu:  return (b == 0) ? {DW{1'b1}} : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation from IDLE, check latency, busy span, result and hold.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp);
        int lat;
        int busy_n;
        bit seen;
        bit overlap;
        lat = 1; busy_n = 0; seen = 0; overlap = 0;
        Op = op; A = a; B = b; Start = 1'b1;
        #1;
        chk({tag, "_stall_req"}, Stall, 1);
        tick();
        Start = 1'b0;
        // Operands must already be latched; scramble the inputs.
        A = $urandom; B = $urandom; Op = 2'($urandom);
        while (!seen && lat <= int'(DW) + 4) begin
            if (Busy) busy_n++;
            if (Busy && Done) overlap = 1;
            if (Done) seen = 1;
            else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_latency"}, lat, DW + 1);
        chk({tag, "_busy_cycles"}, busy_n, DW);
        chk({tag, "_busy_done_overlap"}, overlap, 0);
        chk({tag, "_result"}, Result, exp);
        tick();
        chk({tag, "_done_pulse"}, {Done, Busy}, 2'b00);
        chk({tag, "_result_hold"}, Result, exp);
    endtask

    initial begin
        logic [1:0]    rop;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        int            done_n;
        int            done_at;

        Rst = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0; Flush = 1'b0;

        // Reset state
        tick();
        tick();
        Rst = 1'b1;
        #1;
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_stall", Stall, 0);
        chk("reset_result", Result, 0);

        // Directed multiply / divide
        run_op("mul_7x6", OpMul, 32'd7, 32'd6, 32'h0000_002A);
        run_op("mulhu_ff", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_ff", OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2);
        run_op("divu_by0", OpDivu, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", OpRemu, 32'h1234_5678, 32'd0, 32'h1234_5678);

        // Back-to-back: MUL 3*5 then DIVU 9/2 with Start held through DONE
        Op = OpMul; A = 32'd3; B = 32'd5; Start = 1'b1;
        tick();                              // cycle 1
        Op = OpDivu; A = 32'd9; B = 32'd2;
        repeat (32) tick();                  // cycle 33
        chk("b2b_done1", {Done, Busy}, 2'b10);
        chk("b2b_result1", Result, 32'd15);
        chk("b2b_stall_in_done", Stall, 1);
        tick();                              // cycle 34
        Start = 1'b0;
        chk("b2b_busy_resume", Busy, 1);
        repeat (31) tick();                  // cycle 65
        chk("b2b_not_yet_done", Done, 0);
        tick();                              // cycle 66
        chk("b2b_done2", Done, 1);
        chk("b2b_result2", Result, 32'd4);
        tick();

        // Flush at cycle 10 of a DIVU
        Op = OpDivu; A = 32'd1000; B = 32'd3; Start = 1'b1;
        tick();                              // cycle 1
        Start = 1'b0;
        repeat (9) tick();                   // cycle 10
        Flush = 1'b1;
        tick();                              // cycle 11
        Flush = 1'b0;
        chk("flush_idle_busy", Busy, 0);
        chk("flush_result_kept", Result, 32'd4);
        done_n = 0;
        repeat (30) begin
            if (Done) done_n++;
            tick();
        end
        chk("flush_no_done", done_n, 0);
        chk("flush_result_kept2", Result, 32'd4);

        // Start pulsed during RUN is ignored
        Op = OpMul; A = 32'd7; B = 32'd6; Start = 1'b1;
        tick();                              // cycle 1
        Start = 1'b0;
        repeat (4) tick();                   // cycle 5
        Op = OpDivu; A = 32'd1; B = 32'd1; Start = 1'b1;
        tick();                              // cycle 6
        Start = 1'b0;
        done_n = 0; done_at = 0;
        for (int c = 6; c <= 45; c++) begin
            if (Done) begin
                done_n++;
                done_at = c;
            end
            tick();
        end
        chk("run_start_single_done", done_n, 1);
        chk("run_start_done_cycle", done_at, 33);
        chk("run_start_result", Result, 32'd42);

        // Start+Flush together in IDLE
        Op = OpMul; A = 32'd2; B = 32'd3; Start = 1'b1; Flush = 1'b1;
        #1;
        chk("start_flush_stall", Stall, 0);
        tick();
        Start = 1'b0; Flush = 1'b0;
        chk("start_flush_idle", Busy, 0);
        tick();
        chk("start_flush_no_done", Done, 0);

        // Reset at cycle 20 of a MUL
        Op = OpMul; A = 32'd11; B = 32'd13; Start = 1'b1;
        tick();                              // cycle 1
        Start = 1'b0;
        repeat (19) tick();                  // cycle 20
        chk("rst_mid_busy_before", Busy, 1);
        Rst = 1'b0;
        tick();                              // cycle 21
        Rst = 1'b1;
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_result", Result, 0);
        done_n = 0;
        repeat (20) begin
            if (Done) done_n++;
            tick();
        end
        chk("rst_mid_no_done", done_n, 0);
        run_op("mul_2x2_after_rst", OpMul, 32'd2, 32'd2, 32'd4);

        // Random operations against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? $urandom
                                                         : 32'($urandom_range(1, 1000)));
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_model(rop, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench cannot hang.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_muldiv_iter.md
Name: ex_muldiv_iter

Overview:
Iterative unsigned multiply/divide unit in the execute stage. It sits directly upstream of the EX/MEM pipeline register group. It produces the 32-bit result that the register group captures, and raises Stall so the pipeline holds the register group's enable low while an operation runs. One operation is in flight at a time; each takes a fixed DW iterations.

Parameters:
DW, 32, operand/result width; iteration count equals DW; DW >= 4.

Ports:
Clk  input  1  clock; all state changes on rising edge.
Rst  input  1  synchronous, active-low reset (sampled on rising Clk).
Start  input  1  request a new operation; sampled only in IDLE or DONE.
Op  input  2  00 MUL (low DW bits), 01 MULHU (high DW bits), 10 DIVU (quotient), 11 REMU (remainder).
A  input  DW  operand A (multiplicand / dividend).
B  input  DW  operand B (multiplier / divisor).
Flush  input  1  synchronous abort of any in-flight operation.
Busy  output  1  high while iterating (RUN state).
Stall  output  1  combinational: Busy OR (Start AND state in {IDLE, DONE} AND NOT Flush).
Done  output  1  one-cycle pulse; Result is valid in this cycle.
Result  output  DW  result of the last completed operation.

Behaviour:
- Reset (Rst=0 at an edge):
  - state goes to IDLE; Busy=0, Done=0, Result=0, internal accumulators and counter cleared.
  - Reset dominates Flush and Start.
  - Reset mid-RUN discards the operation; no Done follows.
- States and transitions:
  - IDLE: Start=1 and Flush=0 -> latch A, B, Op, set counter=DW, go to RUN.
  - RUN: one iteration per cycle; decrement counter; when counter reaches 1 at an edge, the final iteration completes and the next state is DONE.
  - DONE: Done=1 for exactly one cycle and Result is updated at the entry edge. Next state is RUN if Start=1 (back-to-back; new operands latched), else IDLE.
- Latency:
  - Start sampled at edge N.
  - Busy=1 in cycles N+1 .. N+DW.
  - Done=1 in cycle N+DW+1.
  - Throughput: one operation per DW+1 cycles.
- Start while in RUN is ignored; operands are not re-latched. Upstream must hold Start/A/B/Op while Stall=1.
- Flush:
  - In RUN or DONE: next state is IDLE, Done is not asserted (or is deasserted), and Result is unchanged.
  - Flush with Start in the same cycle: Flush wins; nothing starts; Stall=0 that cycle.
- Multiply:
  - Shift-add over a 2*DW-bit product register, LSB-first.
  - MUL returns product[DW-1:0]; MULHU returns product[2*DW-1:DW].
  - All arithmetic is unsigned; no overflow flag.
- Divide:
  - Restoring divide, MSB-first, DW-bit remainder with one extra guard bit for the trial subtract.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divide by zero: quotient = all ones, remainder = A. Same latency, no exception.
- Result holds its value between Done pulses; it changes only at DONE entry or on reset.
- Busy and Done are never high in the same cycle.

Test Plan:
1. Rst=0 for 2 edges, then release -> Busy=0, Done=0, Stall=0, Result=0x00000000.
2. MUL A=7, B=6, Start at edge 0 -> Busy cycles 1..32, Done cycle 33, Result=0x0000002A. Repeat with MULHU on A=B=0xFFFFFFFF -> Result=0xFFFFFFFE. MUL on the same operands -> Result=0x00000001.
3. DIVU A=100, B=7 -> Result=14 at cycle 33. REMU on the same operands -> Result=2. DIVU A=0x12345678, B=0 -> Result=0xFFFFFFFF. REMU on the same operands -> Result=0x12345678.
4. Back-to-back: hold Start=1 through DONE of MUL 3*5, with the next op DIVU 9/2 -> Done cycle 33 Result=15, Busy resumes cycle 34, Done cycle 66 Result=4.
5. Flush at cycle 10 of a DIVU -> IDLE at cycle 11, no Done, Result keeps its prior value. Start pulsed during RUN (cycle 5) -> ignored, single Done at cycle 33. Start+Flush together in IDLE -> Stall=0, stays IDLE.
6. Rst=0 at cycle 20 of a MUL -> Busy=0 and Result=0 next cycle, no Done. A new MUL 2*2 after release -> Result=4 at the expected latency.
